csr_counter_ctrl: RTL and testbench

Sequencing controller and storage for the user-level counter CSRs (cycle, time, instret; low halves at 0xC00–0xC02, high halves at 0xC80–0xC82). Accepts one decoded CSR operation at a time from the CSR decode stage, performs read → modify → commit on the addressed 32-bit half, and returns the old value. Between operations it advances the three 64-bit counters every cycle. It owns all arbitration between instruction writes and counter increments.

---
 rtl/csr_counter_ctrl.sv | 153 +++++++++++++++
 tb/tb_csr_counter_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_ctrl.sv
// User-level counter CSRs (cycle/time/instret) with a 4-state read-modify-commit
// sequencer; accept N -> rsp N+3, next accept N+4, req_ready only in IDLE.
module csr_counter_ctrl #(
  parameter int unsigned TIME_DIV = 1,
  parameter bit          WRITABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_sel,
  input  logic [1:0]  req_mode,
  input  logic        req_rd,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        instret_inc
);

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT, RESP} state_e;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_SET   = 2'b10;
  localparam logic [7:0] PRESC_MAX  = 8'(TIME_DIV - 1);

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  mode_q, mode_d;
  logic        rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] new_q, new_d;
  logic        err_q, err_d;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] time_q, time_d;
  logic [63:0] instret_q, instret_d;
  logic [7:0]  presc_q, presc_d;

  logic [63:0] cur_cnt;
  logic [31:0] cur_half;
  logic        sel_ok;
  logic        commit_we;
  logic        tick;

  function automatic logic [63:0] merge_half(input logic [63:0] cur, input logic hi,
                                             input logic [31:0] val);
    merge_half = hi ? {val, cur[31:0]} : {cur[63:32], val};
  endfunction

  // Legal selects are {0,1,2,8,9,10}: bit 2 clear and low pair not 3.
  assign sel_ok = !sel_q[2] && (sel_q[1:0] != 2'd3);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    new_d   = new_q;
    err_d   = err_q;

    case (sel_q[1:0])
      2'd0:    cur_cnt = cycle_q;
      2'd1:    cur_cnt = time_q;
      2'd2:    cur_cnt = instret_q;
      default: cur_cnt = 64'd0;
    endcase
    cur_half = sel_q[3] ? cur_cnt[63:32] : cur_cnt[31:0];

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          sel_d   = req_sel;
          mode_d  = req_mode;
          rd_d    = req_rd;
          wdata_d = req_wdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        old_d = cur_half;
        err_d = !sel_ok || (!WRITABLE && (mode_q != MODE_READ));
        case (mode_q)
          MODE_WRITE: new_d = wdata_q;
          MODE_SET:   new_d = cur_half | wdata_q;
          MODE_READ:  new_d = cur_half;
          default:    new_d = cur_half & ~wdata_q;
        endcase
        state_d = COMMIT;
      end
      COMMIT:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A committing write replaces that counter's whole increment, carry included.
  always_comb begin
    commit_we = (state_q == COMMIT) && !err_q && (mode_q != MODE_READ);
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? 8'd0 : presc_q + 8'd1;
    cycle_d   = cycle_q + 64'd1;
    time_d    = time_q + {63'd0, tick};
    instret_d = instret_q + {63'd0, instret_inc};
    if (commit_we) begin
      case (sel_q[1:0])
        2'd0:    cycle_d   = merge_half(cycle_q, sel_q[3], new_q);
        2'd1:    time_d    = merge_half(time_q, sel_q[3], new_q);
        2'd2:    instret_d = merge_half(instret_q, sel_q[3], new_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= 4'd0;
      mode_q    <= MODE_READ;
      rd_q      <= 1'b0;
      wdata_q   <= 32'd0;
      old_q     <= 32'd0;
      new_q     <= 32'd0;
      err_q     <= 1'b0;
      cycle_q   <= 64'd0;
      time_q    <= 64'd0;
      instret_q <= 64'd0;
      presc_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      old_q     <= old_d;
      new_q     <= new_d;
      err_q     <= err_d;
      cycle_q   <= cycle_d;
      time_q    <= time_d;
      instret_q <= instret_d;
      presc_q   <= presc_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && rd_q && !err_q) ? old_q : 32'd0;

endmodule

// File: tb/tb_csr_counter_ctrl.sv
// Bench for csr_counter_ctrl: a writable and a read-only instance share stimulus;
// a cycle-level model feeds per-instance scoreboards checked by a negedge monitor.
module tb_csr_counter_ctrl;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_sel = 4'd0;
  logic [1:0]  req_mode = 2'd0;
  logic        req_rd = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        instret_inc = 1'b0;

  logic        rw_ready, rw_vld, rw_err;
  logic [31:0] rw_rdata;
  logic        ro_ready, ro_vld, ro_err;
  logic [31:0] ro_rdata;

  csr_counter_ctrl #(.TIME_DIV(TD), .WRITABLE(1'b1)) u_rw (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rw_ready),
    .req_sel(req_sel), .req_mode(req_mode), .req_rd(req_rd), .req_wdata(req_wdata),
    .rsp_valid(rw_vld), .rsp_rdata(rw_rdata), .rsp_err(rw_err), .instret_inc(instret_inc)
  );

  csr_counter_ctrl #(.TIME_DIV(TD), .WRITABLE(1'b0)) u_ro (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ro_ready),
    .req_sel(req_sel), .req_mode(req_mode), .req_rd(req_rd), .req_wdata(req_wdata),
    .rsp_valid(ro_vld), .rsp_rdata(ro_rdata), .rsp_err(ro_err), .instret_inc(instret_inc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: counter values during the current cycle, plus the operation in flight.
  typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;
  rsp_t        q_rw[$];
  rsp_t        q_ro[$];
  logic [63:0] m_cnt [2][3];
  int          m_presc [2];
  int          m_ph [2];
  logic [3:0]  m_sel [2];
  logic [1:0]  m_mode [2];
  logic        m_rd [2];
  logic [31:0] m_wd [2];
  logic        m_err [2];
  logic [31:0] m_new [2];
  bit          started = 0;

  task automatic model_step(input int i);
    int          c;
    bit          hi, ok;
    logic [31:0] old;
    logic [63:0] inc;
    rsp_t        r;
    if (reset) begin
      for (int k = 0; k < 3; k++) m_cnt[i][k] = 64'd0;
      m_presc[i] = 0;
      m_ph[i] = 0;
      if (i == 0) q_rw.delete(); else q_ro.delete();
      return;
    end
    c  = int'(m_sel[i]) % 8;
    hi = (m_sel[i] >= 4'd8);
    ok = (c < 3);
    if (m_ph[i] == 1) begin
      old = 32'd0;
      if (ok) old = hi ? m_cnt[i][c][63:32] : m_cnt[i][c][31:0];
      m_err[i] = !ok || (i == 1 && m_mode[i] != 2'd0);
      case (m_mode[i])
        2'd1:    m_new[i] = m_wd[i];
        2'd2:    m_new[i] = old | m_wd[i];
        2'd3:    m_new[i] = old & ~m_wd[i];
        default: m_new[i] = old;
      endcase
      r.err   = m_err[i];
      r.rdata = (m_rd[i] && !m_err[i]) ? old : 32'd0;
      if (i == 0) q_rw.push_back(r); else q_ro.push_back(r);
    end
    for (int k = 0; k < 3; k++) begin
      if (m_ph[i] == 2 && !m_err[i] && m_mode[i] != 2'd0 && k == c) begin
        if (hi) m_cnt[i][k][63:32] = m_new[i];
        else    m_cnt[i][k][31:0]  = m_new[i];
      end else begin
        if (k == 0)      inc = 64'd1;
        else if (k == 1) inc = (m_presc[i] == TD - 1) ? 64'd1 : 64'd0;
        else             inc = instret_inc ? 64'd1 : 64'd0;
        m_cnt[i][k] = m_cnt[i][k] + inc;
      end
    end
    m_presc[i] = (m_presc[i] == TD - 1) ? 0 : m_presc[i] + 1;
    if (m_ph[i] == 0) begin
      if (req_valid) begin
        m_sel[i] = req_sel; m_mode[i] = req_mode; m_rd[i] = req_rd; m_wd[i] = req_wdata;
        m_ph[i] = 1;
      end
    end else begin
      m_ph[i] = (m_ph[i] + 1) % 4;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (reset) started = 1;
  end

  // Monitor: every response is popped from its scoreboard and compared.
  always @(negedge clk) begin
    rsp_t r;
    if (started) begin
      check("rw_ready_vs_model", {63'd0, rw_ready}, {63'd0, m_ph[0] == 0});
      check("ro_ready_vs_model", {63'd0, ro_ready}, {63'd0, m_ph[1] == 0});
      if (rw_vld) begin
        if (q_rw.size() == 0) check("rw_unexpected_rsp", 64'd1, 64'd0);
        else begin
          r = q_rw.pop_front();
          check("rw_rdata", {32'd0, rw_rdata}, {32'd0, r.rdata});
          check("rw_err", {63'd0, rw_err}, {63'd0, r.err});
        end
      end
      if (ro_vld) begin
        if (q_ro.size() == 0) check("ro_unexpected_rsp", 64'd1, 64'd0);
        else begin
          r = q_ro.pop_front();
          check("ro_rdata", {32'd0, ro_rdata}, {32'd0, r.rdata});
          check("ro_err", {63'd0, ro_err}, {63'd0, r.err});
        end
      end
    end
  end

  bit inc_rand = 0;
  initial begin
    forever begin
      @(negedge clk);
      instret_inc = inc_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Issues one op at a negedge while idle; returns at the negedge after RESP.
  task automatic op(input logic [3:0] sel, input logic [1:0] mode, input logic rd,
                    input logic [31:0] wd, output logic [31:0] rdat, output logic e,
                    output logic [31:0] ro_rdat, output logic ro_e, output int lat);
    int n = 0;
    rdat = 32'd0; e = 1'b0; ro_rdat = 32'd0; ro_e = 1'b0;
    while (!rw_ready && n < 20) begin @(negedge clk); n++; end
    if (!rw_ready) check("ready_timeout", 64'd0, 64'd1);
    req_valid = 1'b1; req_sel = sel; req_mode = mode; req_rd = rd; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rw_vld && lat < 10) begin
      check("busy_ready", {63'd0, rw_ready}, 64'd0);
      @(negedge clk);
      lat++;
    end
    if (!rw_vld) check("rsp_timeout", 64'd0, 64'd1);
    else begin
      rdat = rw_rdata; e = rw_err; ro_rdat = ro_rdata; ro_e = ro_err;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d, rod, t0, t1, rt0, rt1;
    logic        e, roe;
    int          lat;
    logic [3:0]  s;

    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, rw_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, rw_vld}, 64'd0);
    check("reset_rdata", {32'd0, rw_rdata}, 64'd0);
    check("reset_err", {63'd0, rw_err}, 64'd0);
    reset = 1'b0;

    op(4'd0, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("first_read", {32'd0, d}, 64'd1);
    check("first_err", {63'd0, e}, 64'd0);
    check("first_latency", 64'(lat), 64'd3);
    check("first_read_ro", {32'd0, rod}, 64'd1);

    op(4'd0, 2'd1, 1'b0, 32'hFFFF_FFFF, d, e, rod, roe, lat);
    check("wrap_write_rdata", {32'd0, d}, 64'd0);
    check("ro_write_err", {63'd0, roe}, 64'd1);
    op(4'd8, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("wrap_high", {32'd0, d}, 64'd1);
    op(4'd0, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("wrap_low", {32'd0, d}, 64'd5);

    op(4'd2, 2'd1, 1'b0, 32'd1000, d, e, rod, roe, lat);
    op(4'd10, 2'd1, 1'b0, 32'd5, d, e, rod, roe, lat);
    op(4'd2, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("instret_low_drop", {32'd0, d}, 64'd1005);
    op(4'd10, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("instret_high", {32'd0, d}, 64'd5);
    op(4'd10, 2'd2, 1'b1, 32'h0000_00F0, d, e, rod, roe, lat);
    check("set_old", {32'd0, d}, 64'd5);
    op(4'd10, 2'd3, 1'b1, 32'h0000_0030, d, e, rod, roe, lat);
    check("clear_old", {32'd0, d}, 64'hF5);
    op(4'd10, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("setclear_result", {32'd0, d}, 64'hC5);

    op(4'd3, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("sel3_err", {63'd0, e}, 64'd1);
    check("sel3_rdata", {32'd0, d}, 64'd0);
    op(4'd15, 2'd1, 1'b1, 32'hFFFF, d, e, rod, roe, lat);
    check("sel15_err", {63'd0, e}, 64'd1);
    check("sel15_rdata", {32'd0, d}, 64'd0);
    op(4'd1, 2'd1, 1'b1, 32'd7, d, e, rod, roe, lat);
    check("ro_time_write_err", {63'd0, roe}, 64'd1);
    check("ro_time_write_rdata", {32'd0, rod}, 64'd0);

    op(4'd1, 2'd0, 1'b1, 32'd0, t0, e, rt0, roe, lat);
    repeat (16) @(negedge clk);
    op(4'd1, 2'd0, 1'b1, 32'd0, t1, e, rt1, roe, lat);
    check("time_delta", {32'd0, t1 - t0}, 64'd5);
    check("time_delta_ro", {32'd0, rt1 - rt0}, 64'd5);
    op(4'd1, 2'd1, 1'b0, 32'd100, d, e, rod, roe, lat);
    op(4'd1, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);

    req_valid = 1'b1; req_sel = 4'd0; req_mode = 2'd1; req_rd = 1'b1; req_wdata = 32'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_rsp", {63'd0, rw_vld}, 64'd0);
    check("abort_ready", {63'd0, rw_ready}, 64'd1);
    reset = 1'b0;
    op(4'd0, 2'd0, 1'b1, 32'd0, d, e, rod, roe, lat);
    check("abort_cycle_restart", {32'd0, d}, 64'd1);

    inc_rand = 1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) != 0) s = {1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 2))};
      else s = 4'($urandom_range(0, 15));
      op(s, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
         d, e, rod, roe, lat);
    end

    repeat (4) @(negedge clk);
    check("rw_scoreboard_drained", 64'(q_rw.size()), 64'd0);
    check("ro_scoreboard_drained", 64'(q_ro.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
